pc_fetch_ctrl: RTL and testbench

Parametrised second-generation program counter for the single-cycle core, extended for a fetch interface with backpressure.
- Owns the architectural PC, sequential increment and branch/JALR/trap-return redirects.
- Traps misaligned targets to a vector and records the exception PC (EPC).
- Drives a valid/ready request to instruction memory.
- Sits between the control/ALU datapath and the instruction ROM.

---
 rtl/pc_pkg.sv | 19 +
 rtl/pc_ras.sv | 51 +++++
 rtl/pc_fetch_ctrl.sv | 93 +++++++++
 tb/tb_pc_fetch_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared encodings and default constants for the program counter / fetch controller.
package pc_pkg;
  typedef enum logic [1:0] {
    SEL_BR   = 2'b00,
    SEL_JALR = 2'b01,
    SEL_XRET = 2'b10,
    SEL_RSVD = 2'b11
  } redir_sel_e;
  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    WAIT = 2'b10
  } state_e;
  localparam int          DEF_ADDR_W    = 10;
  localparam int          DEF_N         = 32;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h3F0;
  localparam int          DEF_RAS_DEPTH = 4;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; overflow overwrites the oldest entry, underflow is ignored.
module pc_ras #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d, top_idx, widx;
  logic [PW:0] cnt_q, cnt_d;
  logic empty, we;
  assign empty   = cnt_q == '0;
  assign top_idx = ptr_q - PW'(1);
  assign top     = empty ? '0 : mem_q[top_idx];
  // a simultaneous push/pop rewrites the top in place; with nothing stacked it acts as a plain push
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    we    = 1'b0;
    widx  = ptr_q;
    if (push && pop && !empty) begin
      we   = 1'b1;
      widx = top_idx;
    end else if (push) begin
      we    = 1'b1;
      ptr_d = ptr_q + PW'(1);
      cnt_d = (cnt_q == (PW+1)'(DEPTH)) ? cnt_q : cnt_q + (PW+1)'(1);
    end else if (pop && !empty) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - (PW+1)'(1);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem_q[widx] <= din;
  end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter with redirects, misaligned-target trap/EPC and a valid/ready fetch port.
// Defining PC_RAS_EN adds a return-address stack (ras_push/ras_pop/ras_top).
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                N         = DEF_N,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(DEF_TRAP_VEC),
  parameter int                RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redir_valid,
  input  logic [1:0]        redir_sel,
  input  logic [N-1:0]      imm,
  input  logic [N-1:0]      alu_out,
  input  logic              fetch_ready,
`ifdef PC_RAS_EN
  input  logic              ras_push,
  input  logic              ras_pop,
  output logic [ADDR_W-1:0] ras_top,
`endif
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] epc,
  output logic              trap
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, epc_q, epc_d;
  logic trap_q, trap_d, redir, misal;
  logic [N-1:0] target;
  assign redir    = redir_valid && (redir_sel != SEL_RSVD);
  assign pc       = pc_q;
  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign epc      = epc_q;
  assign trap     = trap_q;
  // BR adds the signed offset to the zero-extended pc; truncation to ADDR_W gives modular wrap
  assign target = (redir_sel == SEL_BR)   ? N'(pc_q) + imm :
                  (redir_sel == SEL_JALR) ? alu_out & {{(N-1){1'b1}}, 1'b0} :
                                            N'(epc_q);
  assign misal  = target[1:0] != 2'b00;
  always_comb begin
    state_d     = state_q;
    fetch_valid = state_q != BOOT;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = (!fetch_ready && !redir) ? WAIT : RUN;
      WAIT:    state_d = (fetch_ready || redir) ? RUN : WAIT;
      default: state_d = BOOT;
    endcase
  end
  always_comb begin
    pc_d   = pc_q;
    epc_d  = epc_q;
    trap_d = 1'b0;
    if (redir) begin
      trap_d = misal;
      pc_d   = misal ? TRAP_VEC : target[ADDR_W-1:0];
      epc_d  = misal ? target[ADDR_W-1:0] : epc_q;
    end else if (!stall && fetch_valid && fetch_ready) begin
      pc_d = pc_plus4;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      trap_q  <= trap_d;
    end
  end
`ifdef PC_RAS_EN
  pc_ras #(
    .W    (ADDR_W),
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk (clk),
    .rst (rst),
    .push(ras_push),
    .pop (ras_pop),
    .din (pc_plus4),
    .top (ras_top)
  );
`endif
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed scenarios plus randomized traffic against a behavioural PC model.
module tb_pc_fetch_ctrl;
  localparam int A     = 10;
  localparam int MASK  = (1 << A) - 1;
  localparam int TRAPV = 'h3F0;
  logic clk = 1'b0, rst = 1'b0, stall = 1'b0, redir_valid = 1'b0, fetch_ready = 1'b0;
  logic [1:0] redir_sel = 2'b00;
  logic [31:0] imm = '0, alu_out = '0;
  logic fetch_valid, trap;
  logic [A-1:0] pc, pc_plus4, epc;
`ifdef PC_RAS_EN
  logic ras_push = 1'b0, ras_pop = 1'b0;
  logic [A-1:0] ras_top;
`endif
  int m_pc, m_epc, m_p4;
  bit m_trap, m_fv;
  int ras_q[$];
  int n_checks = 0, n_fail = 0;

  pc_fetch_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .redir_valid(redir_valid), .redir_sel(redir_sel),
    .imm(imm), .alu_out(alu_out), .fetch_ready(fetch_ready),
`ifdef PC_RAS_EN
    .ras_push(ras_push), .ras_pop(ras_pop), .ras_top(ras_top),
`endif
    .fetch_valid(fetch_valid), .pc(pc), .pc_plus4(pc_plus4), .epc(epc), .trap(trap)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 0; m_epc = 0; m_trap = 0; m_fv = 0;
    ras_q.delete();
  endtask

  task automatic tick();
    int t;
    bit r;
    r = redir_valid && redir_sel != 2'b11;
    t = (redir_sel == 2'b00) ? m_pc + $signed(imm) :
        (redir_sel == 2'b01) ? int'(alu_out & ~32'd1) : m_epc;
`ifdef PC_RAS_EN
    if (ras_push && ras_pop && ras_q.size() > 0) ras_q[ras_q.size()-1] = (m_pc + 4) & MASK;
    else if (ras_push) begin
      ras_q.push_back((m_pc + 4) & MASK);
      if (ras_q.size() > 4) void'(ras_q.pop_front());
    end else if (ras_pop && ras_q.size() > 0) void'(ras_q.pop_back());
`endif
    if (r) begin
      m_trap = (t & 3) != 0;
      if (m_trap) begin m_epc = t & MASK; m_pc = TRAPV; end
      else m_pc = t & MASK;
    end else begin
      m_trap = 0;
      if (!stall && m_fv && fetch_ready) m_pc = (m_pc + 4) & MASK;
    end
    m_fv = 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic jump(input int target);
    redir_valid = 1; redir_sel = 2'b01; alu_out = target;
    tick();
    redir_valid = 0;
  endtask

  task automatic test_reset();
    rst = 0; fetch_ready = 1;
    model_reset();
    repeat (2) @(negedge clk);
    if (pc !== 10'h0 || epc !== 10'h0 || trap !== 1'b0 || fetch_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_state got pc=%0h epc=%0h trap=%0b fv=%0b want 0/0/0/0", pc, epc, trap, fetch_valid);
    end
    n_checks++;
    rst = 1;
    #1;
    if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL boot_fv got %0b want 0", fetch_valid); end
    n_checks++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (pc !== A'(4 * i) || fetch_valid !== 1'b1) begin
        n_fail++; $display("FAIL seq_pc step=%0d got pc=%0h fv=%0b want pc=%0h fv=1", i, pc, fetch_valid, 4 * i);
      end
      n_checks++;
    end
  endtask

  task automatic test_backpressure();
    jump(8);
    fetch_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (pc !== 10'h8 || fetch_valid !== 1'b1) begin
        n_fail++; $display("FAIL wait_hold cyc=%0d got pc=%0h fv=%0b want pc=8 fv=1", i, pc, fetch_valid);
      end
      n_checks++;
    end
    fetch_ready = 1;
    tick();
    if (pc !== 10'hC) begin n_fail++; $display("FAIL wait_release got %0h want c", pc); end
    n_checks++;
  endtask

  task automatic test_redirect();
    jump('h10);
    stall = 1; redir_valid = 1; redir_sel = 2'b00; imm = -32'sd8;
    tick();
    if (pc !== 10'h08) begin n_fail++; $display("FAIL br_neg_stall got %0h want 8", pc); end
    n_checks++;
    stall = 0; redir_sel = 2'b01; alu_out = 'h41;
    tick();
    if (pc !== 10'h40) begin n_fail++; $display("FAIL jalr_clr_lsb got %0h want 40", pc); end
    n_checks++;
    redir_sel = 2'b11; alu_out = 'h100;
    tick();
    redir_valid = 0;
    if (pc !== 10'h44 || trap !== 1'b0) begin n_fail++; $display("FAIL rsvd_ignored got pc=%0h trap=%0b want 44/0", pc, trap); end
    n_checks++;
    stall = 1;
    tick();
    if (pc !== 10'h44) begin n_fail++; $display("FAIL stall_hold got %0h want 44", pc); end
    n_checks++;
    stall = 0;
  endtask

  task automatic test_trap();
    jump('h20);
    redir_valid = 1; redir_sel = 2'b00; imm = 2;
    tick();
    redir_valid = 0;
    if (pc !== 10'h3F0 || epc !== 10'h22 || trap !== 1'b1) begin
      n_fail++; $display("FAIL br_trap got pc=%0h epc=%0h trap=%0b want 3f0/22/1", pc, epc, trap);
    end
    n_checks++;
    stall = 1;
    tick();
    if (trap !== 1'b0 || pc !== 10'h3F0) begin n_fail++; $display("FAIL trap_pulse got trap=%0b pc=%0h want 0/3f0", trap, pc); end
    n_checks++;
    stall = 0; redir_valid = 1; redir_sel = 2'b10;
    tick();
    redir_valid = 0;
    if (pc !== 10'h3F0 || epc !== 10'h22 || trap !== 1'b1) begin
      n_fail++; $display("FAIL xret_retrap got pc=%0h epc=%0h trap=%0b want 3f0/22/1", pc, epc, trap);
    end
    n_checks++;
  endtask

  task automatic test_wrap();
    jump('h3FC);
    if (pc_plus4 !== 10'h0) begin n_fail++; $display("FAIL pc_plus4_wrap got %0h want 0", pc_plus4); end
    n_checks++;
    fetch_ready = 1;
    tick();
    if (pc !== 10'h0 || pc_plus4 !== 10'h4) begin n_fail++; $display("FAIL pc_wrap got pc=%0h p4=%0h want 0/4", pc, pc_plus4); end
    n_checks++;
  endtask

  task automatic test_reset_mid_wait();
    jump('h80);
    fetch_ready = 0;
    tick();
    #2 rst = 0;
    #1;
    model_reset();
    if (fetch_valid !== 1'b0 || pc !== 10'h0) begin
      n_fail++; $display("FAIL async_reset got fv=%0b pc=%0h want 0/0", fetch_valid, pc);
    end
    n_checks++;
    @(negedge clk);
    rst = 1; fetch_ready = 1;
    redir_valid = 1; redir_sel = 2'b01; alu_out = 'h80;
    tick();
    redir_valid = 0;
    if (pc !== 10'h80 || fetch_valid !== 1'b1) begin
      n_fail++; $display("FAIL boot_redirect got pc=%0h fv=%0b want 80/1", pc, fetch_valid);
    end
    n_checks++;
  endtask

`ifdef PC_RAS_EN
  task automatic test_ras();
    int exp_pop[5] = '{16, 12, 8, 0, 0};
    rst = 0;
    model_reset();
    @(negedge clk);
    rst = 1; fetch_ready = 1; stall = 0;
    tick();
    ras_push = 1;
    repeat (5) tick();
    ras_push = 0;
    if (ras_top !== 10'd20) begin n_fail++; $display("FAIL ras_full got %0d want 20", ras_top); end
    n_checks++;
    stall = 1; ras_pop = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ras_top !== A'(exp_pop[i])) begin n_fail++; $display("FAIL ras_pop%0d got %0d want %0d", i, ras_top, exp_pop[i]); end
      n_checks++;
    end
    ras_pop = 0; stall = 0;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stall       = ($urandom_range(0, 3) == 0);
      fetch_ready = ($urandom_range(0, 3) != 0);
      redir_valid = ($urandom_range(0, 4) == 0);
      redir_sel   = 2'($urandom_range(0, 3));
      imm         = 32'($urandom_range(0, 80)) - 32'd40;
      alu_out     = $urandom;
`ifdef PC_RAS_EN
      ras_push = ($urandom_range(0, 3) == 0);
      ras_pop  = ($urandom_range(0, 3) == 0);
`endif
      tick();
      m_p4 = (m_pc + 4) & MASK;
      if (pc !== m_pc[A-1:0] || pc_plus4 !== m_p4[A-1:0] || epc !== m_epc[A-1:0] || trap !== m_trap || fetch_valid !== m_fv) begin
        n_fail++;
        $display("FAIL rnd cyc=%0d got pc=%0h p4=%0h epc=%0h trap=%0b fv=%0b want %0h/%0h/%0h/%0b/%0b",
                 i, pc, pc_plus4, epc, trap, fetch_valid, m_pc, m_p4, m_epc, m_trap, m_fv);
      end
      n_checks++;
`ifdef PC_RAS_EN
      if (ras_top !== A'(ras_q.size() ? ras_q[ras_q.size()-1] : 0)) begin
        n_fail++; $display("FAIL rnd_ras cyc=%0d got %0h", i, ras_top);
      end
      n_checks++;
`endif
    end
    redir_valid = 0; stall = 0;
`ifdef PC_RAS_EN
    ras_push = 0; ras_pop = 0;
`endif
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_redirect();
    test_trap();
    test_wrap();
    test_reset_mid_wait();
`ifdef PC_RAS_EN
    test_ras();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
